// File: rtl/am_de_sched_if.sv
// am_de_sched_if: bundles the sample handshake, shared-multiplier, square-root,
// carrier-frequency and envelope-output signals of am_de_sched.
// Latency: none (wires only).  Backpressure: carried by iq_valid/iq_ready.
// Optional macro AM_DE_SCHED_DROP_CNT_EN adds the drop_cnt signal.
// Modports: slave = the scheduler side, master = the environment driving it.
interface am_de_sched_if;
  logic [2:0]  mode;          // block enabled only while mode == 3'b011
  logic        iq_valid;      // I/Q pair offered
  logic [15:0] i_in;          // in-phase sample, two's complement
  logic [15:0] q_in;          // quadrature sample, two's complement
  logic        iq_ready;      // pair accepted when iq_valid is also high
  logic [15:0] mult_a;        // shared signed multiplier operand A
  logic [15:0] mult_b;        // shared signed multiplier operand B
  logic [31:0] mult_p;        // combinational signed product
  logic [31:0] sqrt_radical;  // unsigned radical to the square-root unit
  logic [15:0] sqrt_q;        // square-root result
  logic [23:0] fc_in;         // carrier frequency write data
  logic        fc_wr;         // carrier frequency write strobe
  logic [23:0] fc;            // carrier frequency word to the NCO
  logic [15:0] demod_out;     // envelope sample
  logic        demod_valid;   // one-cycle strobe for demod_out
  logic        busy;          // scheduler not idle

`ifdef AM_DE_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt;      // saturating count of refused offers

  modport slave (
    input  mode, iq_valid, i_in, q_in, mult_p, sqrt_q, fc_in, fc_wr,
    output iq_ready, mult_a, mult_b, sqrt_radical, fc, demod_out, demod_valid, busy,
    output drop_cnt
  );

  modport master (
    output mode, iq_valid, i_in, q_in, mult_p, sqrt_q, fc_in, fc_wr,
    input  iq_ready, mult_a, mult_b, sqrt_radical, fc, demod_out, demod_valid, busy,
    input  drop_cnt
  );
`else
  modport slave (
    input  mode, iq_valid, i_in, q_in, mult_p, sqrt_q, fc_in, fc_wr,
    output iq_ready, mult_a, mult_b, sqrt_radical, fc, demod_out, demod_valid, busy
  );

  modport master (
    output mode, iq_valid, i_in, q_in, mult_p, sqrt_q, fc_in, fc_wr,
    input  iq_ready, mult_a, mult_b, sqrt_radical, fc, demod_out, demod_valid, busy
  );
`endif
endinterface

// File: rtl/am_de_sched.sv
// am_de_sched: AM envelope scheduler computing sqrt(I^2 + Q^2) with one shared
// multiplier and an external square-root unit.
// Latency: handshake cycle N -> demod_valid in cycle N+3+SQRT_LAT; one sample per 3+SQRT_LAT cycles.
// Backpressure: iq_ready is high only in IDLE with mode == 3'b011 and reset low.
// Ports: clk_100M (clock), reset (sync, active-high), bus (am_de_sched_if.slave):
//   mode, iq_valid/i_in/q_in/iq_ready, mult_a/mult_b/mult_p, sqrt_radical/sqrt_q,
//   fc_in/fc_wr/fc, demod_out/demod_valid, busy.
// Optional macro AM_DE_SCHED_DROP_CNT_EN adds bus.drop_cnt, a saturating count of
// cycles where a sample was offered in mode 3'b011 but refused.
module am_de_sched #(
  parameter int unsigned SQRT_LAT = 2  // cycles from stable radical to valid sqrt_q, 1..15
) (
  input logic          clk_100M,
  input logic          reset,
  am_de_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_I = 2'd1,
    SQ_Q = 2'd2,
    SQRT = 2'd3
  } state_t;

  // Value of the wait counter during the final SQRT cycle.
  localparam logic [3:0] LAST_WAIT = 4'(SQRT_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] i_reg;
  logic [15:0] q_reg;
  logic [31:0] acc;
  logic [3:0]  wait_cnt;
  logic [23:0] fc_pend;
  logic [23:0] fc_reg;
  logic [15:0] demod_reg;
  logic        demod_vld_reg;

  logic        enabled;
  logic        iq_ready;
  logic        hs;
  logic        capture;
  logic [15:0] mult_a;
  logic [15:0] mult_b;

  assign enabled  = (bus.mode == 3'b011);
  assign iq_ready = (state == IDLE) && enabled && !reset;
  assign hs       = bus.iq_valid && iq_ready;

  // The square-root result is taken on the last SQRT cycle unless the mode
  // dropped out, in which case the sample is discarded.
  assign capture  = (state == SQRT) && enabled && (wait_cnt == LAST_WAIT);

  // Next state and multiplier operand steering.
  always_comb begin
    state_nxt = state;
    mult_a    = 16'd0;
    mult_b    = 16'd0;
    case (state)
      IDLE: begin
        if (hs) state_nxt = SQ_I;
      end
      SQ_I: begin
        mult_a    = i_reg;
        mult_b    = i_reg;
        state_nxt = enabled ? SQ_Q : IDLE;
      end
      SQ_Q: begin
        mult_a    = q_reg;
        mult_b    = q_reg;
        state_nxt = enabled ? SQRT : IDLE;
      end
      SQRT: begin
        if (!enabled || (wait_cnt == LAST_WAIT)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (reset) begin
      state         <= IDLE;
      i_reg         <= 16'd0;
      q_reg         <= 16'd0;
      acc           <= 32'd0;
      wait_cnt      <= 4'd0;
      fc_pend       <= 24'd0;
      fc_reg        <= 24'd0;
      demod_reg     <= 16'd0;
      demod_vld_reg <= 1'b0;
    end else begin
      state <= state_nxt;

      if (hs) begin
        i_reg <= bus.i_in;
        q_reg <= bus.q_in;
      end

      // Both squares are non-negative, so the signed product is added as
      // unsigned; the largest sum is 2^31 and fits.
      if (state == SQ_I) acc <= bus.mult_p;
      if (state == SQ_Q) begin
        acc      <= acc + bus.mult_p;
        wait_cnt <= 4'd0;
      end
      if (state == SQRT) wait_cnt <= wait_cnt + 4'd1;

      // Shifting left by two keeps sqrt_q[13:0]; the top two bits fall off.
      demod_vld_reg <= capture;
      if (capture) demod_reg <= bus.sqrt_q << 2;

      // Last write wins; the NCO word only moves on an IDLE edge, and a write
      // made in IDLE is forwarded straight through so it shows next cycle.
      if (bus.fc_wr) fc_pend <= bus.fc_in;
      if (state == IDLE) fc_reg <= bus.fc_wr ? bus.fc_in : fc_pend;
    end
  end

  assign bus.iq_ready     = iq_ready;
  assign bus.mult_a       = mult_a;
  assign bus.mult_b       = mult_b;
  assign bus.sqrt_radical = acc;
  assign bus.fc           = fc_reg;
  assign bus.demod_out    = demod_reg;
  assign bus.demod_valid  = demod_vld_reg;
  assign bus.busy         = (state != IDLE);

`ifdef AM_DE_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk_100M) begin
    if (reset) begin
      drop_cnt <= 16'd0;
    end else if (bus.iq_valid && enabled && !iq_ready && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt;
`endif

endmodule

// File: tb/tb_am_de_sched.sv
// tb_am_de_sched: table-driven, hand-sequenced and random checks of am_de_sched
// against an arithmetic reference (I^2+Q^2, floor square root, 14-bit truncation).
// The bench also models the shared multiplier and a square-root unit with SQRT_LAT=2.
module tb_am_de_sched;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  am_de_sched_if bus();

  am_de_sched #(.SQRT_LAT(LAT)) dut (
    .clk_100M (clk),
    .reset    (reset),
    .bus      (bus)
  );

  // Shared signed multiplier (combinational).
  logic signed [31:0] ea, eb;
  assign ea = {{16{bus.mult_a[15]}}, bus.mult_a};
  assign eb = {{16{bus.mult_b[15]}}, bus.mult_b};
  assign bus.mult_p = ea * eb;

  // Square-root unit: result valid LAT cycles after the radical settles.
  logic [31:0] rad_d;
  always @(posedge clk) rad_d <= bus.sqrt_radical;
  assign bus.sqrt_q = isqrt(rad_d);

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [31:0] r, t;
    r = 32'd0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[15:0];
  endfunction

  // Reference model from plain arithmetic.
  function automatic logic [31:0] model_rad(input logic [15:0] i, input logic [15:0] q);
    longint si, sq;
    si = longint'($signed(i));
    sq = longint'($signed(q));
    return 32'(si * si + sq * sq);
  endfunction

  function automatic logic [15:0] model_dem(input logic [31:0] rad);
    int s;
    s = int'($floor($sqrt(real'(rad))));
    return 16'((s % 16384) * 4);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a pair until accepted (bounded); returns in cycle N+1 at edge+1.
  task automatic start_sample(input logic [15:0] i, input logic [15:0] q);
    logic ok;
    ok = 1'b0;
    bus.i_in = i;
    bus.q_in = q;
    bus.iq_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.iq_ready;
      tick();
    end
    bus.iq_valid = 1'b0;
    chk("hs_taken", 32'(ok), 32'd1);
  endtask

  // Full sample: returns radical seen in the first SQRT cycle, demod_out and latency.
  task automatic do_sample(input logic [15:0] i, input logic [15:0] q,
                           output logic [31:0] rad, output logic [15:0] dem, output int lat);
    start_sample(i, q);
    lat = 1;
    rad = 32'd0;
    while (!bus.demod_valid && lat < 40) begin
      if (lat == 1) chk("mult_sq_i", {bus.mult_a, bus.mult_b}, {i, i});
      if (lat == 2) chk("mult_sq_q", {bus.mult_a, bus.mult_b}, {q, q});
      if (lat == 3) begin
        rad = bus.sqrt_radical;
        chk("mult_zero_sqrt", {bus.mult_a, bus.mult_b}, 32'd0);
      end
      tick();
      lat++;
    end
    dem = bus.demod_out;
    tick();
    chk("valid_one_cycle", 32'(bus.demod_valid), 32'd0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30 && bus.busy; k++) tick();
    chk("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [31:0] rad;
    logic [15:0] dem;
  } vec_t;

  vec_t vt[8];

`ifdef AM_DE_SCHED_DROP_CNT_EN
  logic [15:0] dprev;
`endif

  initial begin
    logic [31:0] rad;
    logic [15:0] dem, dem_prev, ri, rq;
    int lat, prev, nhs, nvld;

    vt[0] = '{16'd3000,  16'd4000,  32'd25000000, 16'd20000};
    vt[1] = '{16'h8000,  16'h8000,  32'h80000000, 16'd54288};
    vt[2] = '{16'd0,     16'd0,     32'd0,        16'd0};
    vt[3] = '{16'd1,     16'd0,     32'd1,        16'd4};
    vt[4] = '{16'hFFFF,  16'hFFFF,  32'd2,        16'd4};
    vt[5] = '{16'd100,   16'd0,     32'd10000,    16'd400};
    vt[6] = '{16'd32767, 16'd32767, 32'd2147352578, 16'd54284};
    vt[7] = '{16'd3,     16'hFFFC,  32'd25,       16'd20};

    bus.mode = 3'b011;
    bus.iq_valid = 1'b0;
    bus.i_in = 16'd0;
    bus.q_in = 16'd0;
    bus.fc_in = 24'd0;
    bus.fc_wr = 1'b0;
    reset = 1'b1;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.demod_valid), 32'd0);
    chk("rst_demod", 32'(bus.demod_out), 32'd0);
    chk("rst_fc", 32'(bus.fc), 32'd0);
    chk("rst_radical", bus.sqrt_radical, 32'd0);
    chk("rst_mult", {bus.mult_a, bus.mult_b}, 32'd0);
    chk("rst_ready_in_reset", 32'(bus.iq_ready), 32'd0);
`ifdef AM_DE_SCHED_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
`endif
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.iq_ready), 32'd1);
    tick();

    // Table of directed samples.
    for (int n = 0; n < 8; n++) begin
      do_sample(vt[n].i, vt[n].q, rad, dem, lat);
      chk($sformatf("tab%0d_radical", n), rad, vt[n].rad);
      chk($sformatf("tab%0d_demod", n), 32'(dem), 32'(vt[n].dem));
      chk($sformatf("tab%0d_latency", n), 32'(lat), 32'(3 + LAT));
    end

    // Back-to-back offers: accepted every 3+LAT cycles, valid aligned with next accept.
    bus.i_in = 16'd3;
    bus.q_in = 16'd4;
    bus.iq_valid = 1'b1;
    prev = -1;
    nhs = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (bus.iq_ready) begin
        if (prev >= 0) begin
          chk("b2b_gap", 32'(c - prev), 32'(3 + LAT));
          chk("b2b_valid", {31'd0, bus.demod_valid}, 32'd1);
`ifdef AM_DE_SCHED_DROP_CNT_EN
          chk("b2b_drop_step", 32'(bus.drop_cnt - dprev), 32'd4);
`endif
        end
`ifdef AM_DE_SCHED_DROP_CNT_EN
        dprev = bus.drop_cnt;
`endif
        prev = c;
        nhs++;
      end
      tick();
    end
    bus.iq_valid = 1'b0;
    chk("b2b_count", 32'(nhs), 32'd4);
    wait_idle();
    tick();

    // Mode dropped during SQRT: abort, no strobe, demod_out held.
    dem_prev = bus.demod_out;
    start_sample(16'd1000, 16'd0);
    tick();
    tick();
    chk("abort_in_sqrt", 32'(bus.busy), 32'd1);
    bus.mode = 3'b000;
    tick();
    chk("abort_idle", 32'(bus.busy), 32'd0);
    nvld = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.demod_valid) nvld++;
      tick();
    end
    chk("abort_no_valid", 32'(nvld), 32'd0);
    chk("abort_demod_held", 32'(bus.demod_out), 32'(dem_prev));
    @(negedge clk);
    chk("ready_mode_off", 32'(bus.iq_ready), 32'd0);
    tick();
    bus.mode = 3'b011;

    // Carrier frequency updates only on IDLE edges.
    bus.fc_in = 24'h0000AA;
    bus.fc_wr = 1'b1;
    tick();
    bus.fc_wr = 1'b0;
    @(negedge clk);
    chk("fc_idle_next", 32'(bus.fc), 32'h0000AA);
    tick();
    start_sample(16'd5, 16'd12);
    tick();
    bus.fc_in = 24'h123456;
    bus.fc_wr = 1'b1;
    tick();
    bus.fc_in = 24'h654321;
    @(negedge clk);
    chk("fc_hold_sqrt0", 32'(bus.fc), 32'h0000AA);
    tick();
    bus.fc_wr = 1'b0;
    @(negedge clk);
    chk("fc_hold_sqrt1", 32'(bus.fc), 32'h0000AA);
    tick();
    @(negedge clk);
    chk("fc_hold_first_idle", 32'(bus.fc), 32'h0000AA);
    chk("fc_sample_valid", 32'(bus.demod_valid), 32'd1);
    chk("fc_sample_demod", 32'(bus.demod_out), 32'd52);
    tick();
    @(negedge clk);
    chk("fc_last_wins", 32'(bus.fc), 32'h654321);
    tick();

    // One-cycle reset during SQ_I.
    start_sample(16'd700, 16'd800);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_mult", {bus.mult_a, bus.mult_b}, 32'd0);
    chk("mrst_radical", bus.sqrt_radical, 32'd0);
    chk("mrst_fc", 32'(bus.fc), 32'd0);
    chk("mrst_demod", 32'(bus.demod_out), 32'd0);
    chk("mrst_valid", 32'(bus.demod_valid), 32'd0);
    chk("mrst_ready", 32'(bus.iq_ready), 32'd1);
    nvld = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (bus.demod_valid) nvld++;
    end
    chk("mrst_no_valid", 32'(nvld), 32'd0);
    tick();

    // Random samples against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      if (n % 8 == 0) ri = 16'h8000;
      repeat ($urandom_range(0, 2)) tick();
      do_sample(ri, rq, rad, dem, lat);
      chk("rnd_radical", rad, model_rad(ri, rq));
      chk("rnd_demod", 32'(dem), 32'(model_dem(model_rad(ri, rq))));
      chk("rnd_latency", 32'(lat), 32'(3 + LAT));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
